linear_network_multicast_scheduler: RTL and testbench
=====================================================

Name: linear_network_multicast_scheduler

Overview:
- Shares one linear multicast network (1-bit one-hot/multi-hot command per node, combinational) among NUM_REQ requesters.
- Each request carries one data word and a destination mask.
- Round-robin arbitration selects a request into a 1-entry holding register, then issues it into the network. Issue is gated by per-node ready, so a multicast can be split over several cycles until every destination has received the word.
- All network-side outputs are registered, so they drive the network inputs directly.

Parameters:
- DATA_WIDTH, 32, payload width of each request and of the network.
- NUM_NODE, 4, number of network nodes; also the command width.
- NUM_REQ, 3, number of requesters (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_req_valid  input  NUM_REQ  request valid, one bit per requester.
- i_req_data  input  NUM_REQ*DATA_WIDTH  requester r payload at [r*DATA_WIDTH+:DATA_WIDTH].
- i_req_dest  input  NUM_REQ*NUM_NODE  requester r destination mask at [r*NUM_NODE+:NUM_NODE]; bit n selects node n.
- o_req_ready  output  NUM_REQ  one-hot accept; combinational, and depends on i_req_valid.
- i_node_ready  input  NUM_NODE  node n can take a word this cycle.
- o_net_valid  output  1  drives network i_valid.
- o_net_en  output  1  drives network i_en; equals o_net_valid.
- o_net_data_bus  output  DATA_WIDTH  drives network i_data_bus.
- o_net_cmd  output  NUM_NODE  drives network i_cmd.
- o_busy  output  1  holding register occupied (registered state).

Behaviour:
- Reset (synchronous, active-high):
  - hold_vld=0, rr_ptr=0.
  - o_net_valid=0, o_net_en=0, o_net_data_bus=0, o_net_cmd=0, o_busy=0.
  - o_req_ready=0 while rst is high.
- State:
  - hold_vld, hold_id, hold_data, hold_mask[NUM_NODE], rr_ptr.
  - Two states: IDLE (hold_vld=0) and HOLD (hold_vld=1).
- Issue logic, in HOLD:
  - send_mask = hold_mask & i_node_ready.
  - If send_mask != 0, the next cycle shows o_net_valid=1, o_net_en=1, o_net_data_bus=hold_data, o_net_cmd=send_mask.
  - Otherwise the next cycle shows o_net_valid=0 and o_net_cmd=0; o_net_data_bus holds its last value.
  - hold_mask <= hold_mask & ~send_mask.
- Completion:
  - finishing = hold_vld & ((hold_mask & ~i_node_ready) == 0).
  - On finishing the entry retires (HOLD->IDLE) unless a new request loads in the same cycle (HOLD->HOLD).
- Load:
  - can_load = ~hold_vld | finishing.
  - If can_load and any i_req_valid is set, the round-robin winner is granted: it is the first valid requester starting at rr_ptr, wrapping around.
  - Grant means o_req_ready[winner]=1, the holding register loads that requester's data and dest, and hold_id is set to the winner.
  - rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
- Zero destination mask:
  - The request is accepted (handshake completes) and dropped; hold_vld stays/becomes 0.
  - It still advances rr_ptr and produces no network output.
- Latency and throughput:
  - A word accepted in cycle T reaches the network at T+2 when its destinations are ready.
  - Sustained throughput is 1 request per cycle when all destinations are ready.
- Partial fan-out:
  - Ready nodes receive the word first; the remaining bits retry each cycle.
  - The word is never delivered twice to the same node.
  - Blocked nodes stall the whole scheduler with no timeout.
- Requester rule: a requester holds its data and dest stable while valid=1 and ready=0.
- Reset mid-operation:
  - A partially delivered holding entry is discarded without further output.
  - The requester is not re-granted it; the entry was already accepted.
- Outputs are only meaningful when o_net_valid=1; o_net_data_bus is not zeroed on idle cycles.

Decomposition:
- Shared header/package:
  - Localparams for command width (=NUM_NODE).
  - Bus slicing helpers for the requester data and dest buses.
  - FSM state encoding: IDLE=0, HOLD=1.
- One sub-module: rr_arbiter_onehot (NUM_REQ).
  - Inputs: request vector, enable (=can_load).
  - Outputs: one-hot grant.
  - Holds and updates its pointer internally on grant.

Test Plan:
- Reset: hold rst 3 cycles with i_req_valid=3'b111 -> o_req_ready=0, o_net_valid=0, o_net_cmd=0, o_busy=0 throughout.
- Unicast: req0 data=32'hA5A5_0001, dest=4'b0100, all nodes ready, accepted at T -> at T+2 o_net_valid=1, o_net_cmd=4'b0100, o_net_data_bus=32'hA5A5_0001; one cycle only.
- Split multicast: dest=4'b1011 with i_node_ready=4'b0011 for 2 cycles, then 4'b1111 -> cmd 4'b0011 once, then 0, then 4'b1000; o_busy drops after the final issue; no node sees the word twice.
- Round-robin: all 3 requesters valid continuously, all dest=4'b1111 -> grants 0,1,2,0,1,2 on consecutive cycles; network valid every cycle from cycle 2 onward.
- Zero destination: req1 dest=4'b0000 -> ready pulse for 1 cycle, no o_net_valid, rr_ptr advances so req2 wins next.
- Reset mid-split: dest=4'b1111 with node3 not ready, assert rst after first issue -> no further o_net_valid; after reset the first grant goes to requester 0.

Source files
------------

// File: rtl/linear_network_multicast_scheduler_pkg.sv
// Shared definitions for the multicast scheduler: default sizes, FSM encoding
// and helpers for slicing the flattened requester buses.
package linear_network_multicast_scheduler_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_NODE   = 4;
    localparam int DEFAULT_NUM_REQ    = 3;
    localparam int CMD_WIDTH          = DEFAULT_NUM_NODE;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // LSB position of requester idx inside a flattened bus of width-bit fields
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int rr_next(input int idx, input int count);
        return (idx == count - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/linear_network_multicast_scheduler_if.sv
// Requester handshake and network-side bus of the multicast scheduler.
// The scheduler uses the slave modport; the driving environment uses master.
interface linear_network_multicast_scheduler_if
    import linear_network_multicast_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_NODE   = CMD_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ
) ();

    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ*NUM_NODE-1:0]   i_req_dest;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_NODE-1:0]           i_node_ready;
    logic                          o_net_valid;
    logic                          o_net_en;
    logic [DATA_WIDTH-1:0]         o_net_data_bus;
    logic [NUM_NODE-1:0]           o_net_cmd;
    logic                          o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_req_dest, i_node_ready,
        output o_req_ready, o_net_valid, o_net_en, o_net_data_bus, o_net_cmd, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_req_dest, i_node_ready,
        input  o_req_ready, o_net_valid, o_net_en, o_net_data_bus, o_net_cmd, o_busy
    );

endinterface

// File: rtl/linear_network_multicast_scheduler_rr_arbiter_onehot.sv
// Round-robin arbiter with one-hot grant; the search starts at the internal
// pointer, which moves to just past the winner whenever a grant is issued.
module rr_arbiter_onehot
    import linear_network_multicast_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic             found;
    int               win;

    // Two passes emulate the wrap-around: first indices at/after ptr, then below it
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found    = 1'b1;
                win      = j;
                grant[j] = en;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                found    = 1'b1;
                win      = j;
                grant[j] = en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= PTR_W'(rr_next(win, NUM_REQ));
        end
    end

endmodule

// File: rtl/linear_network_multicast_scheduler.sv
// Shares one linear multicast network among several requesters through a
// single holding register; multicasts are split across cycles by node ready.
module linear_network_multicast_scheduler
    import linear_network_multicast_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_NODE   = CMD_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
    input logic                                 clk,
    input logic                                 rst,
    linear_network_multicast_scheduler_if.slave bus
);

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [NUM_NODE-1:0]   hold_mask;
    logic                  net_valid;
    logic [DATA_WIDTH-1:0] net_data;
    logic [NUM_NODE-1:0]   net_cmd;

    logic                  hold_vld;
    logic [NUM_NODE-1:0]   send_mask;
    logic                  finishing;
    logic                  can_load;
    logic [NUM_REQ-1:0]    grant;
    logic                  load_fire;
    logic [DATA_WIDTH-1:0] load_data;
    logic [NUM_NODE-1:0]   load_dest;

    assign hold_vld  = (state == HOLD);
    assign send_mask = hold_vld ? (hold_mask & bus.i_node_ready) : '0;
    assign finishing = hold_vld && ((hold_mask & ~bus.i_node_ready) == '0);
    assign can_load  = !hold_vld || finishing;
    assign load_fire = |grant;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.i_req_valid),
        .en    (can_load && !rst),
        .grant (grant)
    );

    // Grant is one-hot, so OR-ing the gated fields selects the winner's payload
    always_comb begin
        load_data = '0;
        load_dest = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                load_data = load_data | bus.i_req_data[slice_lsb(r, DATA_WIDTH) +: DATA_WIDTH];
                load_dest = load_dest | bus.i_req_dest[slice_lsb(r, NUM_NODE) +: NUM_NODE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_mask <= '0;
            net_valid <= 1'b0;
            net_data  <= '0;
            net_cmd   <= '0;
        end else begin
            if (send_mask != '0) begin
                net_valid <= 1'b1;
                net_data  <= hold_data;
                net_cmd   <= send_mask;
            end else begin
                net_valid <= 1'b0;
                net_cmd   <= '0;
            end
            hold_mask <= hold_mask & ~send_mask;
            // A zero-destination request completes its handshake but is never held
            if (load_fire) begin
                hold_data <= load_data;
                hold_mask <= load_dest;
                state     <= (load_dest != '0) ? HOLD : IDLE;
            end else if (finishing) begin
                state <= IDLE;
            end
        end
    end

    assign bus.o_req_ready    = grant;
    assign bus.o_net_valid    = net_valid;
    assign bus.o_net_en       = net_valid;
    assign bus.o_net_data_bus = net_data;
    assign bus.o_net_cmd      = net_cmd;
    assign bus.o_busy         = hold_vld;

endmodule

// File: tb/tb_linear_network_multicast_scheduler.sv
// Scoreboard bench: stimulus queues expected grants and network words with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_linear_network_multicast_scheduler;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int NR = 3;

    typedef struct {
        int id;
        int cyc;
    } grant_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [NN-1:0] cmd;
        int            cyc;
    } net_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   compared;
    int   mismatched;

    grant_exp_t grant_q[$];
    net_exp_t   net_q[$];

    linear_network_multicast_scheduler_if #(
        .DATA_WIDTH (DW),
        .NUM_NODE   (NN),
        .NUM_REQ    (NR)
    ) bus ();

    linear_network_multicast_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_NODE   (NN),
        .NUM_REQ    (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [DW-1:0] d, input logic [NN-1:0] m);
        bus.i_req_data[r*DW +: DW] = d;
        bus.i_req_dest[r*NN +: NN] = m;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NN-1:0] node_ready);
        bus.i_req_valid  = valid;
        bus.i_node_ready = node_ready;
    endtask

    task automatic expect_grant(input int id, input int c);
        grant_exp_t g;
        g.id  = id;
        g.cyc = c;
        grant_q.push_back(g);
    endtask

    task automatic expect_net(input logic [DW-1:0] d, input logic [NN-1:0] m, input int c);
        net_exp_t n;
        n.data = d;
        n.cmd  = m;
        n.cyc  = c;
        net_q.push_back(n);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every grant and every network word must match the next queued expectation
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (bus.o_req_ready != '0) begin
                compared++;
                if (grant_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL grant_unexpected: got ready=%b expected none (cycle %0d)", bus.o_req_ready, cyc);
                end else begin
                    grant_exp_t g;
                    logic [NR-1:0] exp_ready;
                    g = grant_q.pop_front();
                    exp_ready = 3'b001 << g.id;
                    if (bus.o_req_ready !== exp_ready || cyc != g.cyc) begin
                        mismatched++;
                        $display("[TB] FAIL grant: got ready=%b at cycle %0d expected ready=%b at cycle %0d",
                                 bus.o_req_ready, cyc, exp_ready, g.cyc);
                    end
                end
            end
            if (bus.o_net_valid === 1'b1) begin
                compared++;
                if (net_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL net_unexpected: got cmd=%b data=0x%0h expected no issue (cycle %0d)",
                             bus.o_net_cmd, bus.o_net_data_bus, cyc);
                end else begin
                    net_exp_t n;
                    n = net_q.pop_front();
                    if (bus.o_net_cmd !== n.cmd || bus.o_net_data_bus !== n.data ||
                        bus.o_net_en !== 1'b1 || cyc != n.cyc) begin
                        mismatched++;
                        $display("[TB] FAIL net_issue: got cmd=%b data=0x%0h en=%b cycle %0d expected cmd=%b data=0x%0h en=1 cycle %0d",
                                 bus.o_net_cmd, bus.o_net_data_bus, bus.o_net_en, cyc, n.cmd, n.data, n.cyc);
                    end
                end
            end else begin
                compared++;
                if (bus.o_net_cmd !== '0 || bus.o_net_en !== 1'b0 || bus.o_net_valid !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL net_idle: got valid=%b en=%b cmd=%b expected 0/0/0000 (cycle %0d)",
                             bus.o_net_valid, bus.o_net_en, bus.o_net_cmd, cyc);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 32'h0, 4'b1111);
        applyStimulus(3'b111, 4'b1111);

        // Reset held with all requesters valid
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset_req_ready", 32'(bus.o_req_ready), 32'h0);
            checkOutput("reset_net_valid", 32'(bus.o_net_valid), 32'h0);
            checkOutput("reset_net_cmd",   32'(bus.o_net_cmd),   32'h0);
            checkOutput("reset_busy",      32'(bus.o_busy),      32'h0);
        end
        tick();
        rst = 1'b0;
        applyStimulus(3'b000, 4'b1111);

        // Round-robin with all requesters valid, full fan-out
        tick();
        for (int r = 0; r < NR; r++) set_req(r, 32'h1000_0000 + r, 4'b1111);
        applyStimulus(3'b111, 4'b1111);
        for (int k = 0; k < 6; k++) begin
            expect_grant(k % 3, cyc);
            expect_net(32'h1000_0000 + (k % 3), 4'b1111, cyc + 2);
            tick();
        end
        applyStimulus(3'b000, 4'b1111);
        repeat (4) tick();

        // Unicast
        set_req(0, 32'hA5A5_0001, 4'b0100);
        applyStimulus(3'b001, 4'b1111);
        expect_grant(0, cyc);
        expect_net(32'hA5A5_0001, 4'b0100, cyc + 2);
        tick();
        applyStimulus(3'b000, 4'b1111);
        repeat (4) tick();

        // Split multicast
        set_req(0, 32'hC0DE_0B0B, 4'b1011);
        applyStimulus(3'b001, 4'b0011);
        expect_grant(0, cyc);
        expect_net(32'hC0DE_0B0B, 4'b0011, cyc + 2);
        expect_net(32'hC0DE_0B0B, 4'b1000, cyc + 4);
        tick();
        applyStimulus(3'b000, 4'b0011);
        tick();
        tick();
        applyStimulus(3'b000, 4'b1111);
        @(negedge clk);
        checkOutput("split_busy_mid", 32'(bus.o_busy), 32'h1);
        tick();
        @(negedge clk);
        checkOutput("split_busy_done", 32'(bus.o_busy), 32'h0);
        repeat (4) tick();

        // Zero destination, then rr pointer must favour requester 2 over 0
        set_req(1, 32'hDEAD_0000, 4'b0000);
        applyStimulus(3'b010, 4'b1111);
        expect_grant(1, cyc);
        tick();
        set_req(0, 32'h0000_0AAA, 4'b0001);
        set_req(2, 32'h2222_0002, 4'b0110);
        applyStimulus(3'b101, 4'b1111);
        expect_grant(2, cyc);
        expect_net(32'h2222_0002, 4'b0110, cyc + 2);
        @(negedge clk);
        checkOutput("zero_dest_not_held", 32'(bus.o_busy), 32'h0);
        tick();
        applyStimulus(3'b001, 4'b1111);
        expect_grant(0, cyc);
        expect_net(32'h0000_0AAA, 4'b0001, cyc + 2);
        tick();
        applyStimulus(3'b000, 4'b1111);
        repeat (4) tick();

        // Reset in the middle of a split multicast
        set_req(0, 32'h5151_0F0F, 4'b1111);
        applyStimulus(3'b001, 4'b0111);
        expect_grant(0, cyc);
        expect_net(32'h5151_0F0F, 4'b0111, cyc + 2);
        tick();
        applyStimulus(3'b000, 4'b0111);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(3'b000, 4'b1111);
        tick();
        @(negedge clk);
        checkOutput("reset_mid_busy",      32'(bus.o_busy),      32'h0);
        checkOutput("reset_mid_net_valid", 32'(bus.o_net_valid), 32'h0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        set_req(0, 32'h0000_1111, 4'b0001);
        set_req(1, 32'h0000_2222, 4'b0010);
        applyStimulus(3'b011, 4'b1111);
        expect_grant(0, cyc);
        expect_net(32'h0000_1111, 4'b0001, cyc + 2);
        tick();
        applyStimulus(3'b010, 4'b1111);
        expect_grant(1, cyc);
        expect_net(32'h0000_2222, 4'b0010, cyc + 2);
        tick();
        applyStimulus(3'b000, 4'b1111);
        repeat (5) tick();

        @(negedge clk);
        checkOutput("grant_queue_drained", 32'(grant_q.size()), 32'h0);
        checkOutput("net_queue_drained",   32'(net_q.size()),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
